// File: rtl/snoop_bus_initiator.sv
// Cache-side snooping bus initiator: 4-line direct-mapped MSI cache, RM/WM/INV.
// Optional WAIT abort compiled in with `define SNOOP_INITIATOR_TIMEOUT_EN.
module snoop_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Req_Valid,
    input  logic        i_Req_Write,
    input  logic [2:0]  i_Req_Tag,
    input  logic [6:0]  i_Req_Data,
    output logic        o_Req_Ready,
    output logic        o_Resp_Valid,
    output logic [6:0]  o_Resp_Data,
    output logic        o_Resp_Err,
    output logic        o_Bus_Req,
    input  logic        i_Bus_Grant,
    output logic [23:0] o_Bus,
    input  logic [23:0] i_Bus,
    input  logic        i_Bus_Valid
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_ARB    = 3'd2;
    localparam logic [2:0] S_BUS    = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [1:0] L_I = 2'd0;
    localparam logic [1:0] L_S = 2'd1;
    localparam logic [1:0] L_M = 2'd2;

    localparam logic [1:0] OP_RM  = 2'd0;
    localparam logic [1:0] OP_WM  = 2'd1;
    localparam logic [1:0] OP_INV = 2'd2;

    logic [2:0] state;
    logic       req_write;
    logic [2:0] req_tag;
    logic [6:0] req_data;
    logic [1:0] op;
    logic       wb;
    logic [2:0] wb_tag;
    logic [6:0] wb_data;
    logic [6:0] resp_data;
    logic       resp_err;

    logic [1:0] line_st   [4];
    logic [2:0] line_tag  [4];
    logic [6:0] line_data [4];

    logic [1:0] idx;
    logic       hit;
    logic       rsp_match;
    logic       timeout;
    logic       bus_act;

    assign idx       = req_tag[1:0];
    assign hit       = (line_st[idx] != L_I) && (line_tag[idx] == req_tag);
    assign rsp_match = i_Bus_Valid && (i_Bus[22:21] == OP_RM)
                       && (i_Bus[20:18] == req_tag);

`ifdef SNOOP_INITIATOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n)
            wait_cnt <= '0;
        else if (state == S_BUS)
            wait_cnt <= '0;
        else if (state == S_WAIT)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
`endif

    logic unused_bus;
    assign unused_bus = ^{i_Bus[23], i_Bus[10:0]};

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state     <= S_IDLE;
            req_write <= 1'b0;
            req_tag   <= '0;
            req_data  <= '0;
            op        <= OP_RM;
            wb        <= 1'b0;
            wb_tag    <= '0;
            wb_data   <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                line_st[i]   <= L_I;
                line_tag[i]  <= '0;
                line_data[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_Req_Valid) begin
                        req_write <= i_Req_Write;
                        req_tag   <= i_Req_Tag;
                        req_data  <= i_Req_Data;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    resp_err <= 1'b0;
                    wb       <= 1'b0;
                    wb_tag   <= '0;
                    wb_data  <= '0;
                    if (hit && !req_write) begin
                        resp_data <= line_data[idx];
                        state     <= S_DONE;
                    end else if (hit && line_st[idx] == L_M) begin
                        line_data[idx] <= req_data;
                        resp_data      <= req_data;
                        state          <= S_DONE;
                    end else if (hit) begin
                        op    <= OP_INV;
                        state <= S_ARB;
                    end else begin
                        op <= req_write ? OP_WM : OP_RM;
                        // Modified victim rides along on the miss word
                        if (line_st[idx] == L_M) begin
                            wb      <= 1'b1;
                            wb_tag  <= line_tag[idx];
                            wb_data <= line_data[idx];
                        end
                        state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (i_Bus_Grant)
                        state <= S_BUS;
                end
                S_BUS: begin
                    if (op == OP_RM) begin
                        state <= S_WAIT;
                    end else begin
                        line_st[idx]   <= L_M;
                        line_tag[idx]  <= req_tag;
                        line_data[idx] <= req_data;
                        resp_data      <= req_data;
                        state          <= S_DONE;
                    end
                end
                S_WAIT: begin
                    if (rsp_match) begin
                        line_st[idx]   <= L_S;
                        line_tag[idx]  <= req_tag;
                        line_data[idx] <= i_Bus[17:11];
                        resp_data      <= i_Bus[17:11];
                        state          <= S_DONE;
                    end else if (timeout) begin
                        resp_err  <= 1'b1;
                        resp_data <= '0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_act      = (state == S_BUS) || (state == S_WAIT);
    assign o_Req_Ready  = (state == S_IDLE) && i_Reset_n;
    assign o_Bus_Req    = bus_act || (state == S_ARB);
    assign o_Bus        = bus_act ?
                          {1'b1, op, req_tag,
                           (op == OP_WM) ? req_data : 7'd0,
                           wb, wb_tag, wb_data} : 24'd0;
    assign o_Resp_Valid = (state == S_DONE);
    assign o_Resp_Data  = (state == S_DONE) ? resp_data : 7'd0;
    assign o_Resp_Err   = (state == S_DONE) && resp_err;

endmodule
